// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDRAM state codes, command encodings and default timings
package sdram_pkg;
    localparam logic [2:0] S_POWERUP_WAIT = 3'd0;
    localparam logic [2:0] S_PRECHARGE    = 3'd1;
    localparam logic [2:0] S_WAIT_TRP     = 3'd2;
    localparam logic [2:0] S_REFRESH      = 3'd3;
    localparam logic [2:0] S_WAIT_TRFC    = 3'd4;
    localparam logic [2:0] S_LOAD_MODE    = 3'd5;
    localparam logic [2:0] S_WAIT_TMRD    = 3'd6;
    localparam logic [2:0] S_DONE         = 3'd7;
    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP       = 4'b1111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;
    localparam int          DEF_CLK_FREQ_MHZ = 133;
    localparam int          DEF_T_POWERUP_US = 200;
    localparam int          DEF_T_RP         = 3;
    localparam int          DEF_T_RFC        = 9;
    localparam int          DEF_T_MRD        = 2;
    localparam int          DEF_N_REFRESH    = 8;
    localparam logic [11:0] DEF_MODE_REG     = 12'h030;
endpackage

// File: rtl/sdram_init_ctrl_if.sv
// sdram_init_ctrl_if: SDRAM command pins plus init_done, controller drives as master
interface sdram_init_ctrl_if;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [11:0] addr;
    logic [1:0]  ba;
    logic        cke;
    logic        init_done;
    modport master (output cs_n, ras_n, cas_n, we_n, addr, ba, cke, init_done);
    modport slave  (input  cs_n, ras_n, cas_n, we_n, addr, ba, cke, init_done);
endinterface

// File: rtl/sdram_init_ctrl.sv
// sdram_init_ctrl: SDRAM power-up/precharge/refresh/mode-load sequencer; SDRAM_INIT_SIM_FAST_EN shortens power-up to 100 cycles
module sdram_init_ctrl
    import sdram_pkg::*;
#(
    parameter int          CLK_FREQ_MHZ = DEF_CLK_FREQ_MHZ,
    parameter int          T_POWERUP_US = DEF_T_POWERUP_US,
    parameter int          T_RP         = DEF_T_RP,
    parameter int          T_RFC        = DEF_T_RFC,
    parameter int          T_MRD        = DEF_T_MRD,
    parameter int          N_REFRESH    = DEF_N_REFRESH,
    parameter logic [11:0] MODE_REG     = DEF_MODE_REG
) (
    input  logic               clk,
    input  logic               rst,
    sdram_init_ctrl_if.master  o_bus
);
`ifdef SDRAM_INIT_SIM_FAST_EN
    localparam int P = 100;
`else
    localparam int P = CLK_FREQ_MHZ * T_POWERUP_US;
`endif
    localparam int CW = $clog2(P + 1);
    localparam int RW = $clog2(N_REFRESH + 1);
    // Wait states run with the counter at 0..T-2; T=1 skips the wait state entirely.
    localparam logic [CW-1:0] P_END   = CW'(P);
    localparam logic [CW-1:0] RP_END  = CW'(T_RP  > 1 ? T_RP  - 2 : 0);
    localparam logic [CW-1:0] RFC_END = CW'(T_RFC > 1 ? T_RFC - 2 : 0);
    localparam logic [CW-1:0] MRD_END = CW'(T_MRD > 1 ? T_MRD - 2 : 0);

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [CW-1:0] r_cnt;
    logic [RW-1:0] r_ref;
    logic          r_cke;
    logic [3:0]    w_cmd;

    // Next-state selection; r_ref counts refreshes already issued before this cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_POWERUP_WAIT: w_next = (r_cnt == P_END) ? S_PRECHARGE : S_POWERUP_WAIT;
            S_PRECHARGE:    w_next = (T_RP > 1) ? S_WAIT_TRP : S_REFRESH;
            S_WAIT_TRP:     w_next = (r_cnt == RP_END) ? S_REFRESH : S_WAIT_TRP;
            S_REFRESH:      w_next = (T_RFC > 1) ? S_WAIT_TRFC :
                                     (r_ref == RW'(N_REFRESH - 1)) ? S_LOAD_MODE : S_REFRESH;
            S_WAIT_TRFC:    w_next = (r_cnt != RFC_END) ? S_WAIT_TRFC :
                                     (r_ref == RW'(N_REFRESH)) ? S_LOAD_MODE : S_REFRESH;
            S_LOAD_MODE:    w_next = (T_MRD > 1) ? S_WAIT_TMRD : S_DONE;
            S_WAIT_TMRD:    w_next = (r_cnt == MRD_END) ? S_DONE : S_WAIT_TMRD;
            default:        w_next = S_DONE;
        endcase
    end

    // State, shared wait counter (restarts on every state change, parks in DONE) and refresh tally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_POWERUP_WAIT;
            r_cnt   <= '0;
            r_ref   <= '0;
            r_cke   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cke   <= 1'b1;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state != S_DONE)
                r_cnt <= r_cnt + 1'b1;
            if (r_state == S_REFRESH)
                r_ref <= r_ref + 1'b1;
        end
    end

    assign w_cmd = (r_state == S_PRECHARGE) ? CMD_PRECHARGE :
                   (r_state == S_REFRESH)   ? CMD_REFRESH   :
                   (r_state == S_LOAD_MODE) ? CMD_LOAD_MODE : CMD_NOP;
    assign {o_bus.cs_n, o_bus.ras_n, o_bus.cas_n, o_bus.we_n} = w_cmd;
    assign o_bus.addr      = (r_state == S_PRECHARGE) ? 12'h400 :
                             (r_state == S_LOAD_MODE) ? MODE_REG : 12'h000;
    assign o_bus.ba        = 2'b00;
    assign o_bus.cke       = r_cke;
    assign o_bus.init_done = (r_state == S_DONE);
endmodule

// File: tb/tb_sdram_init_ctrl.sv
// tb_sdram_init_ctrl: directed checks of the SDRAM init sequence on three parameter sets
module tb_sdram_init_ctrl;
    import sdram_pkg::*;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [11:0] addr;
        logic [1:0]  ba;
        logic        cke;
        logic        done;
    } obs_t;

    localparam obs_t RST_OBS  = '{cmd: 4'b1111, addr: 12'h000, ba: 2'b00, cke: 1'b0, done: 1'b0};
    localparam obs_t DONE_OBS = '{cmd: 4'b1111, addr: 12'h000, ba: 2'b00, cke: 1'b1, done: 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    sdram_init_ctrl_if b0();
    sdram_init_ctrl_if b1();
    sdram_init_ctrl_if b2();

    sdram_init_ctrl #(.CLK_FREQ_MHZ(1), .T_POWERUP_US(100)) u_main (.clk(clk), .rst(rst), .o_bus(b0));
    sdram_init_ctrl #(.CLK_FREQ_MHZ(1), .T_POWERUP_US(10))  u_slow (.clk(clk), .rst(rst), .o_bus(b1));
    sdram_init_ctrl #(.CLK_FREQ_MHZ(1), .T_POWERUP_US(100), .N_REFRESH(2), .T_RFC(1))
        u_b2b (.clk(clk), .rst(rst), .o_bus(b2));

    function automatic obs_t get(int i);
        if (i == 0) return {b0.cs_n, b0.ras_n, b0.cas_n, b0.we_n, b0.addr, b0.ba, b0.cke, b0.init_done};
        if (i == 1) return {b1.cs_n, b1.ras_n, b1.cas_n, b1.we_n, b1.addr, b1.ba, b1.cke, b1.init_done};
        return {b2.cs_n, b2.ras_n, b2.cas_n, b2.we_n, b2.addr, b2.ba, b2.cke, b2.init_done};
    endfunction

    // Expected pins in cycle k for power-up length p and the given timings
    function automatic obs_t exp_at(int k, int p, int trp, int nref, int trfc, int tmrd);
        obs_t e;
        int rf0, lm;
        rf0 = p + trp;
        lm  = rf0 + nref * trfc;
        e = '{cmd: 4'b1111, addr: 12'h000, ba: 2'b00, cke: 1'b1, done: (k >= lm + tmrd)};
        if (k == p) begin
            e.cmd = 4'b0010;
            e.addr = 12'h400;
        end else if (k >= rf0 && k < lm && (k - rf0) % trfc == 0) begin
            e.cmd = 4'b0001;
        end else if (k == lm) begin
            e.cmd = 4'b0000;
            e.addr = 12'h030;
        end
        return e;
    endfunction

    // Reset, then release on a falling edge so the next rising edge is cycle 0
    task automatic restart();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            o = get(i);
            n_total++;
            if (o !== RST_OBS) $display("FAIL reset inst=%0d got=%h exp=%h", i, o, RST_OBS);
            else n_pass++;
        end
    endtask

    task automatic test_sequence();
        obs_t o, e;
        int n_pre, n_ref, n_load, n_nop, first_pre, first_done;
        n_pre = 0; n_ref = 0; n_load = 0; n_nop = 0; first_pre = -1; first_done = -1;
        restart();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            o = get(0);
            e = exp_at(k, 100, 3, 8, 9, 2);
            n_total++;
            if (o !== e) $display("FAIL seq k=%0d got=%h exp=%h", k, o, e);
            else n_pass++;
            if (o.cmd == 4'b0010) n_pre++;
            if (o.cmd == 4'b0001) n_ref++;
            if (o.cmd == 4'b0000) n_load++;
            if (o.cmd == 4'b1111) n_nop++;
            if (o.cmd == 4'b0010 && first_pre < 0) first_pre = k;
            if (o.done && first_done < 0) first_done = k;
        end
        n_total++;
        if (n_pre !== 1) $display("FAIL precharge_count got=%0d exp=1", n_pre); else n_pass++;
        n_total++;
        if (n_ref !== 8) $display("FAIL refresh_count got=%0d exp=8", n_ref); else n_pass++;
        n_total++;
        if (n_load !== 1) $display("FAIL load_count got=%0d exp=1", n_load); else n_pass++;
        n_total++;
        if (n_nop !== 190) $display("FAIL nop_count got=%0d exp=190", n_nop); else n_pass++;
        n_total++;
        if (first_pre !== 100) $display("FAIL first_precharge got=%0d exp=100", first_pre); else n_pass++;
        n_total++;
        if (first_done !== 177) $display("FAIL first_done got=%0d exp=177", first_done); else n_pass++;
    endtask

    task automatic test_async_reset();
        obs_t o, e;
        int first_pre;
        first_pre = -1;
        restart();
        for (int k = 0; k <= 148; k++) @(negedge clk);
        o = get(0);
        n_total++;
        if (o.cmd !== 4'b0001) $display("FAIL pre_abort_refresh got=%h exp=1", o.cmd); else n_pass++;
        #2 rst = 1'b1;
        #1 o = get(0);
        n_total++;
        if (o !== RST_OBS) $display("FAIL async_abort got=%h exp=%h", o, RST_OBS); else n_pass++;
        @(negedge clk);
        #2 rst = 1'b0;
        for (int k = 0; k < 180; k++) begin
            @(negedge clk);
            o = get(0);
            e = exp_at(k, 100, 3, 8, 9, 2);
            n_total++;
            if (o !== e) $display("FAIL restart k=%0d got=%h exp=%h", k, o, e);
            else n_pass++;
            if (o.cmd == 4'b0010 && first_pre < 0) first_pre = k;
        end
        n_total++;
        if (first_pre !== 100) $display("FAIL restart_precharge got=%0d exp=100", first_pre); else n_pass++;
    endtask

    task automatic test_done_hold();
        obs_t o, e;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            o = get(0);
            n_total++;
            if (o !== DONE_OBS) $display("FAIL done_hold k=%0d got=%h exp=%h", k, o, DONE_OBS);
            else n_pass++;
        end
        #2 rst = 1'b1;
        #1 o = get(0);
        n_total++;
        if (o !== RST_OBS) $display("FAIL done_abort got=%h exp=%h", o, RST_OBS); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 110; k++) begin
            @(negedge clk);
            o = get(0);
            e = exp_at(k, 100, 3, 8, 9, 2);
            n_total++;
            if (o !== e) $display("FAIL done_restart k=%0d got=%h exp=%h", k, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_slow_build();
        obs_t o, e;
        int first_pre, first_done;
        first_pre = -1; first_done = -1;
        restart();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            o = get(1);
            e = exp_at(k, 10, 3, 8, 9, 2);
            n_total++;
            if (o !== e) $display("FAIL slow k=%0d got=%h exp=%h", k, o, e);
            else n_pass++;
            if (o.cmd == 4'b0010 && first_pre < 0) first_pre = k;
            if (o.done && first_done < 0) first_done = k;
        end
        n_total++;
        if (first_pre !== 10) $display("FAIL slow_precharge got=%0d exp=10", first_pre); else n_pass++;
        n_total++;
        if (first_done !== 87) $display("FAIL slow_done got=%0d exp=87", first_done); else n_pass++;
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        logic [3:0] c103, c104, c105;
        c103 = 4'hx; c104 = 4'hx; c105 = 4'hx;
        restart();
        for (int k = 0; k < 115; k++) begin
            @(negedge clk);
            o = get(2);
            e = exp_at(k, 100, 3, 2, 1, 2);
            n_total++;
            if (o !== e) $display("FAIL b2b k=%0d got=%h exp=%h", k, o, e);
            else n_pass++;
            if (k == 103) c103 = o.cmd;
            if (k == 104) c104 = o.cmd;
            if (k == 105) c105 = o.cmd;
        end
        n_total++;
        if (c103 !== 4'b0001) $display("FAIL b2b_ref103 got=%h exp=1", c103); else n_pass++;
        n_total++;
        if (c104 !== 4'b0001) $display("FAIL b2b_ref104 got=%h exp=1", c104); else n_pass++;
        n_total++;
        if (c105 !== 4'b0000) $display("FAIL b2b_load105 got=%h exp=0", c105); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_async_reset();
        test_done_hold();
        test_slow_build();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
